// File: rtl/seg7_scan_if.sv
// Pin-level bundle between the datapath and the seven-segment scan driver.
// The datapath (master) drives display data; the driver (slave) drives the board pins.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lz_suppress;
  logic [DIGITS-1:0]     an_n;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic                  frame_tick;

  modport master (
    output load, value, dp_in, blank_mask, lz_suppress,
    input  an_n, seg_n, dp_n, frame_tick
  );

  modport slave (
    input  load, value, dp_in, blank_mask, lz_suppress,
    output an_n, seg_n, dp_n, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: latches a hex word and scans
// one digit per slot, with a dark guard interval at the start of every slot.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Hex nibble to active-low abcdefg glyph
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic [CW-1:0]         cnt_r;
  logic [IW-1:0]         idx_r;
  logic [4*DIGITS-1:0]   val_r;
  logic [DIGITS-1:0]     dp_r;
  logic [DIGITS-1:0]     blank_r;
  logic [DIGITS-1:0]     an_n_r;
  logic [6:0]            seg_n_r;
  logic                  dp_n_r;
  logic                  frame_tick_r;

  logic [CW-1:0]         cnt_s;
  logic [IW-1:0]         idx_s;
  logic                  tick_s;
  logic [DIGITS-1:0]     an_n_s;
  logic [6:0]            seg_n_s;
  logic                  dp_n_s;
  logic [DIGITS-1:0]     dark_s;
  logic [3:0]            nib_s;
  logic                  lz_run_s;

  // Per-digit dark flags: forced blank, or inside the run of leading zeros
  always_comb begin
    dark_s   = {DIGITS{1'b0}};
    lz_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run_s = lz_run_s & (val_r[4*i +: 4] == 4'h0);
      if (blank_r[i]) begin
        dark_s[i] = 1'b1;
      end else if (bus.lz_suppress && (i > 0) && lz_run_s) begin
        dark_s[i] = 1'b1;
      end else begin
        dark_s[i] = 1'b0;
      end
    end
  end

  assign nib_s = val_r[{idx_r, 2'b00} +: 4];

  // Slot counter, digit index and next registered pin values
  always_comb begin
    cnt_s   = cnt_r + CW'(1);
    idx_s   = idx_r;
    tick_s  = 1'b0;
    an_n_s  = {DIGITS{1'b1}};
    seg_n_s = 7'b1111111;
    dp_n_s  = 1'b1;

    if (cnt_r == CNT_LAST) begin
      cnt_s = {CW{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_s  = {IW{1'b0}};
        tick_s = 1'b1;
      end else begin
        idx_s  = idx_r + IW'(1);
        tick_s = 1'b0;
      end
    end else begin
      cnt_s = cnt_r + CW'(1);
    end

    // Guard cycles keep every anode off so the previous digit cannot ghost
    if (cnt_r < CNT_GUARD) begin
      an_n_s  = {DIGITS{1'b1}};
      seg_n_s = 7'b1111111;
      dp_n_s  = 1'b1;
    end else begin
      an_n_s = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
      if (dark_s[idx_r]) begin
        seg_n_s = 7'b1111111;
        dp_n_s  = 1'b1;
      end else begin
        seg_n_s = glyph(nib_s);
        dp_n_s  = ~dp_r[idx_r];
      end
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r        <= {CW{1'b0}};
      idx_r        <= {IW{1'b0}};
      val_r        <= {(4*DIGITS){1'b0}};
      dp_r         <= {DIGITS{1'b0}};
      blank_r      <= {DIGITS{1'b0}};
      an_n_r       <= {DIGITS{1'b1}};
      seg_n_r      <= 7'b1111111;
      dp_n_r       <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      an_n_r       <= an_n_s;
      seg_n_r      <= seg_n_s;
      dp_n_r       <= dp_n_s;
      frame_tick_r <= tick_s;
      if (bus.load) begin
        val_r   <= bus.value;
        dp_r    <= bus.dp_in;
        blank_r <= bus.blank_mask;
      end else begin
        val_r   <= val_r;
        dp_r    <= dp_r;
        blank_r <= blank_r;
      end
    end
  end

  assign bus.an_n       = an_n_r;
  assign bus.seg_n      = seg_n_r;
  assign bus.dp_n       = dp_n_r;
  assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=8, GUARD=2) with a
// cycle-level reference model feeding an expected-output scoreboard queue.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int G  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          m_cnt  = 0;
  int          m_idx  = 0;
  logic [15:0] m_val  = 16'h0000;
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_bl   = 4'h0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  4'hF: return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Pins expected after the coming edge, from model state and current inputs
  function automatic exp_t predict();
    exp_t e;
    logic dark;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
    if (rst_n === 1'b1) begin
      e.ft = (m_cnt == RD - 1) && (m_idx == D - 1);
      if (m_cnt >= G) begin
        e.an[m_idx] = 1'b0;
        dark = m_bl[m_idx] || ((bus.lz_suppress === 1'b1) && (m_idx > 0) &&
                               ((m_val >> (4 * m_idx)) == 16'h0000));
        if (!dark) begin
          e.seg = ref_glyph(m_val[4*m_idx +: 4]);
          e.dp  = ~m_dp[m_idx];
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    sb.push_back(predict());
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_cnt = 0; m_idx = 0; m_val = 16'h0; m_dp = 4'h0; m_bl = 4'h0;
    end else begin
      if (bus.load === 1'b1) begin
        m_val = bus.value; m_dp = bus.dp_in; m_bl = bus.blank_mask;
      end
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % D;
      end else begin
        m_cnt++;
      end
    end
    #1;
    e = sb.pop_front();
    check("an_n", bus.an_n, e.an);
    check("seg_n", bus.seg_n, e.seg);
    check("dp_n", bus.dp_n, e.dp);
    check("frame_tick", bus.frame_tick, e.ft);
    check("one_anode", ($countones(~bus.an_n) <= 1), 1);
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus.value = v; bus.dp_in = dp; bus.blank_mask = bl; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  // Advance to the first active cycle of digit d, then check literal pin values
  task automatic show(input int d, input logic [6:0] seg_e, input logic dp_e, input string tag);
    bit         hit = 1'b0;
    logic [3:0] an_e;
    for (int k = 0; k < 64 && !hit; k++) begin
      if (m_idx == d && m_cnt == G) hit = 1'b1;
      step();
    end
    an_e = 4'hF;
    an_e[d] = 1'b0;
    check({tag, "_found"}, hit, 1);
    check({tag, "_an"}, bus.an_n, an_e);
    check({tag, "_seg"}, bus.seg_n, seg_e);
    check({tag, "_dp"}, bus.dp_n, dp_e);
  endtask

  initial begin
    int   ft_cnt;
    int   lo_cnt[4];
    int   last;
    int   cur;
    bit   ok;
    logic [15:0] words[4];

    rst_n = 1'b0;
    bus.load = 1'b0; bus.value = 16'h0; bus.dp_in = 4'h0;
    bus.blank_mask = 4'h0; bus.lz_suppress = 1'b0;
    repeat (2) step();
    check("reset_an", bus.an_n, 4'hF);
    check("reset_seg", bus.seg_n, 7'h7F);
    rst_n = 1'b1;

    // Glyph sweep
    load_word(16'h0A5F, 4'b0010, 4'b0000);
    show(0, 7'b0111000, 1'b1, "sweep_d0");
    show(1, 7'b0100100, 1'b0, "sweep_d1");
    show(2, 7'b0001000, 1'b1, "sweep_d2");
    show(3, 7'b0000001, 1'b1, "sweep_d3");
    words = '{16'h1234, 16'h5678, 16'h9BCD, 16'hE0E0};
    foreach (words[w]) begin
      load_word(words[w], 4'b0000, 4'b0000);
      repeat (34) step();
    end

    // Leading-zero suppression
    bus.lz_suppress = 1'b1;
    load_word(16'h0070, 4'b0000, 4'b0000);
    show(3, 7'h7F, 1'b1, "lz70_d3");
    show(2, 7'h7F, 1'b1, "lz70_d2");
    show(1, 7'b0001111, 1'b1, "lz70_d1");
    show(0, 7'b0000001, 1'b1, "lz70_d0");
    load_word(16'h0000, 4'b0000, 4'b0000);
    show(1, 7'h7F, 1'b1, "lz00_d1");
    show(2, 7'h7F, 1'b1, "lz00_d2");
    show(3, 7'h7F, 1'b1, "lz00_d3");
    show(0, 7'b0000001, 1'b1, "lz00_d0");
    bus.lz_suppress = 1'b0;
    show(1, 7'b0000001, 1'b1, "nolz_d1");
    show(2, 7'b0000001, 1'b1, "nolz_d2");
    show(3, 7'b0000001, 1'b1, "nolz_d3");
    show(0, 7'b0000001, 1'b1, "nolz_d0");

    // Blank mask and load latency
    load_word(16'h0000, 4'b1111, 4'b0101);
    show(0, 7'h7F, 1'b1, "blank_d0");
    show(1, 7'b0000001, 1'b0, "blank_d1");
    show(2, 7'h7F, 1'b1, "blank_d2");
    show(3, 7'b0000001, 1'b0, "blank_d3");
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (m_idx == 1 && m_cnt == 3) ok = 1'b1;
      else step();
    end
    check("lat_sync", ok, 1);
    load_word(16'h1111, 4'b1111, 4'b0101);
    check("lat_old", bus.seg_n, 7'b0000001);
    step();
    check("lat_new", bus.seg_n, 7'b1001111);

    // Scan order and frame tick over 64 cycles
    load_word(16'h8888, 4'b0000, 4'b0000);
    ft_cnt = 0; last = -1;
    lo_cnt = '{0, 0, 0, 0};
    for (int k = 0; k < 64; k++) begin
      step();
      if (bus.frame_tick === 1'b1) ft_cnt++;
      cur = -1;
      for (int b = 0; b < 4; b++) if (bus.an_n[b] === 1'b0) cur = b;
      if (cur >= 0) begin
        lo_cnt[cur]++;
        if (last >= 0 && cur != last) check("scan_order", cur, (last + 1) % 4);
        last = cur;
      end
    end
    check("ft_per_64", ft_cnt, 2);
    for (int b = 0; b < 4; b++) check("slot_len", lo_cnt[b], 12);

    // Reset mid-scan
    repeat (11) step();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_an", bus.an_n, 4'hF);
      check("rst_seg", bus.seg_n, 7'h7F);
      check("rst_dp", bus.dp_n, 1'b1);
      check("rst_ft", bus.frame_tick, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("rel1_an", bus.an_n, 4'hF);
    step();
    check("rel2_an", bus.an_n, 4'hF);
    step();
    check("rel3_an", bus.an_n, 4'b1110);
    check("rel3_seg", bus.seg_n, 7'b0000001);
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
